mips_multicycle_control: RTL and testbench

//  Multicycle sequencer for the MIPS datapath. It drives PC, IR, memory, register-file, ALU-source and ALU-op selects one phase per cycle.

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/mc_mem_timer.sv | 30 +++
 rtl/mips_multicycle_control.sv | 229 ++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, ALU-op encodings, datapath mux
// select encodings and the bundle of control strobes driven by the sequencer.
package mips_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU-op encodings understood by alu_control
    localparam logic [1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [1:0] ALU_OP_FUNC = 2'b10;

    // ALU B-operand select
    typedef enum logic [1:0] {
        SRCB_RT      = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    // Next-PC select
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pc_src_t;

    // Every strobe and select the sequencer drives in one cycle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        logic [1:0] alu_op;
        pc_src_t    pc_src;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // True for the opcodes this sequencer knows how to execute
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Wait-cycle counter for memory phases. Counts cycles a memory phase is held
// without a completed handshake and flags when the limit has been reached.
module mc_mem_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic wait_en,
    output logic expired
);

    localparam int unsigned TW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [TW-1:0] cnt_q;

    // Clear has priority; otherwise count waited cycles, parking at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (wait_en && (cnt_q != TW'(LIMIT))) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign expired = (cnt_q == TW'(LIMIT));

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS sequencer: steps fetch/decode/execute/memory/writeback one
// phase per cycle and drives the datapath mux selects and write strobes.
//
// Memory handshake: while the sequencer sits in a memory phase (FETCH, MEM_RD,
// MEM_WR) its request (mem_read or mem_write) is held steady; the memory raises
// mem_ready in the cycle the access completes, and that is the only cycle the
// completion strobes (ir_write/pc_write, or instr_done for a store) fire. If the
// wait reaches MEM_TIMEOUT without mem_ready, the sequencer latches mem_err and
// parks in HALT. mem_ready has no effect in any other state.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_src,
    output logic                 instr_done,
    output logic                 illegal_op,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        WB_R     = 4'd7,
        EXEC_I   = 4'd8,
        WB_I     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12
    } state_t;

    state_t                 state_q, state_d;
    logic                   is_load_q;
    logic                   mem_err_q;
    logic [CNT_WIDTH-1:0]   instr_count_q;
    ctrl_t                  ctrl;
    ctrl_t                  ctrl_out;

    logic mem_phase;
    logic expired;
    logic hold;
    logic timeout_hit;

    // Timer bookkeeping: a memory phase is held while it waits below the limit
    assign mem_phase   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign hold        = mem_phase && !mem_ready && !expired;
    assign timeout_hit = mem_phase && !mem_ready && expired;

    // Any state change clears the count, so every memory phase starts from zero
    mc_mem_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .wait_en (hold),
        .expired (expired)
    );

    // Next-state selection; a ready on the limit cycle still completes
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (mem_ready)    state_d = DECODE;
                else if (expired) state_d = HALT;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = EXEC_I;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADDR: state_d = is_load_q ? MEM_RD : MEM_WR;
            MEM_RD: begin
                if (mem_ready)    state_d = MEM_WB;
                else if (expired) state_d = HALT;
            end
            MEM_WR: begin
                if (mem_ready)    state_d = FETCH;
                else if (expired) state_d = HALT;
            end
            EXEC_R:  state_d = WB_R;
            EXEC_I:  state_d = WB_I;
            MEM_WB, WB_R, WB_I, BRANCH, JUMP: state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // Moore decode of the current state plus the mem_ready-qualified strobes
    always_comb begin
        ctrl = '0;
        unique case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_OP_ADD;
                if (!is_supported(opcode)) begin
                    ctrl.illegal_op = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            MEM_ADDR, EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_WR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_OP_FUNC;
            end
            WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            is_load_q     <= 1'b0;
            mem_err_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                is_load_q <= (opcode == OP_LW);
            end
            if (timeout_hit) begin
                mem_err_q <= 1'b1;
            end
            if (ctrl.instr_done) begin
                instr_count_q <= instr_count_q + CNT_WIDTH'(1);
            end
        end
    end

    // Reset forces every strobe low at once, even though state already reads FETCH
    assign ctrl_out = rst ? '0 : ctrl;

    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign reg_dst       = ctrl_out.reg_dst;
    assign reg_write     = ctrl_out.reg_write;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_op        = ctrl_out.alu_op;
    assign pc_src        = ctrl_out.pc_src;
    assign instr_done    = ctrl_out.instr_done;
    assign illegal_op    = ctrl_out.illegal_op;
    assign mem_err       = mem_err_q;
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle sequencer with a per-cycle output scoreboard.
module tb_mips_multicycle_control;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_WIDTH   = 2;
    localparam int          VW          = 1 + CNT_WIDTH + 18;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [5:0]           opcode;
    logic                 mem_ready;
    logic                 pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic                 ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]           alu_src_b, alu_op, pc_src;
    logic                 instr_done, illegal_op, mem_err;
    logic [CNT_WIDTH-1:0] instr_count;

    int errors = 0;
    int checks = 0;

    logic [VW-1:0]        exp_q[$];
    logic [CNT_WIDTH-1:0] exp_cnt;
    logic                 exp_err;

    logic [17:0] F_WAIT, F_RDY, DEC, DEC_ILL, MADDR, MRD, MWB, MWR_WAIT, MWR_RDY;
    logic [17:0] EXR, WBR, EXI, WBI, BR, JMP, ZERO;

    mips_multicycle_control #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .mem_err       (mem_err),
        .instr_count   (instr_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Expected control word, fields in port order
    function automatic logic [17:0] c(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rdst,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic [1:0] psrc, input logic done,
        input logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, ill};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {mem_err, instr_count, pc_write, pc_write_cond, i_or_d, mem_read,
                mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_src, instr_done, illegal_op};
    endfunction

    // Pop the oldest expectation and compare it with the live outputs
    task automatic check(input string tag);
        logic [VW-1:0] e;
        logic [VW-1:0] got;
        e   = exp_q.pop_front();
        got = observed();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, e);
        end
    endtask

    // Driver: called at a falling edge; drive inputs, check the cycle, advance
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [17:0] e);
        opcode    = op;
        mem_ready = rdy;
        exp_q.push_back({exp_err, exp_cnt, e});
        #1;
        check(tag);
        if (e[1]) exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    initial begin
        F_WAIT   = c(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        F_RDY    = c(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        DEC      = c(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
        DEC_ILL  = c(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,1);
        MADDR    = c(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        MRD      = c(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        MWB      = c(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
        MWR_WAIT = c(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        MWR_RDY  = c(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
        EXR      = c(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
        WBR      = c(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
        EXI      = c(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        WBI      = c(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);
        BR       = c(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
        JMP      = c(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
        ZERO     = '0;

        // Reset
        rst = 1'b1; opcode = 6'b0; mem_ready = 1'b1;
        exp_cnt = '0; exp_err = 1'b0;
        @(negedge clk);
        #1;
        exp_q.push_back({exp_err, exp_cnt, ZERO});
        check("reset_outputs");
        @(negedge clk);
        rst = 1'b0;

        // R-type, ready high
        cyc("r_fetch",  6'b000000, 1'b1, F_RDY);
        cyc("r_decode", 6'b000000, rnd(), DEC);
        cyc("r_exec",   6'b000000, rnd(), EXR);
        cyc("r_wb",     6'b000000, rnd(), WBR);

        // lw with three not-ready cycles in MEM_RD
        cyc("lw_fetch",  6'b100011, 1'b1, F_RDY);
        cyc("lw_decode", 6'b100011, rnd(), DEC);
        cyc("lw_addr",   6'b100011, rnd(), MADDR);
        for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 6'b100011, 1'b0, MRD);
        cyc("lw_rd_done", 6'b100011, 1'b1, MRD);
        cyc("lw_wb",      6'b100011, rnd(), MWB);

        // beq (with a slow fetch) then j back-to-back
        cyc("beq_fetch_wait", 6'b000100, 1'b0, F_WAIT);
        cyc("beq_fetch_wait", 6'b000100, 1'b0, F_WAIT);
        cyc("beq_fetch",  6'b000100, 1'b1, F_RDY);
        cyc("beq_decode", 6'b000100, rnd(), DEC);
        cyc("beq_branch", 6'b000100, rnd(), BR);
        cyc("j_fetch",    6'b000010, 1'b1, F_RDY);
        cyc("j_decode",   6'b000010, rnd(), DEC);
        cyc("j_jump",     6'b000010, rnd(), JMP);

        // Unsupported opcode behaves as a counted nop
        cyc("ill_fetch",  6'b111111, 1'b1, F_RDY);
        cyc("ill_decode", 6'b111111, rnd(), DEC_ILL);
        cyc("ill_refetch", 6'b000000, 1'b0, F_WAIT);
        cyc("ill_refetch_done", 6'b001000, 1'b1, F_RDY);

        // addi (fetched above)
        cyc("addi_decode", 6'b001000, rnd(), DEC);
        cyc("addi_exec",   6'b001000, rnd(), EXI);
        cyc("addi_wb",     6'b001000, rnd(), WBI);

        // sw completing exactly at the timeout limit: no error
        cyc("sw_fetch",  6'b101011, 1'b1, F_RDY);
        cyc("sw_decode", 6'b101011, rnd(), DEC);
        cyc("sw_addr",   6'b101011, rnd(), MADDR);
        for (int i = 0; i < 4; i++) cyc("sw_wr_wait", 6'b101011, 1'b0, MWR_WAIT);
        cyc("sw_wr_limit_ready", 6'b101011, 1'b1, MWR_RDY);

        // sw that never completes: timeout, mem_err, HALT
        cyc("swto_fetch",  6'b101011, 1'b1, F_RDY);
        cyc("swto_decode", 6'b101011, rnd(), DEC);
        cyc("swto_addr",   6'b101011, rnd(), MADDR);
        for (int i = 0; i < 5; i++) cyc("swto_wr_wait", 6'b101011, 1'b0, MWR_WAIT);
        exp_err = 1'b1;
        for (int i = 0; i < 4; i++) cyc("halt_idle", 6'($urandom_range(0, 63)), rnd(), ZERO);

        // Leave HALT through reset
        rst = 1'b1;
        exp_cnt = '0; exp_err = 1'b0;
        #1;
        exp_q.push_back({exp_err, exp_cnt, ZERO});
        check("halt_reset");
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in the middle of a stalled store
        cyc("rsw_fetch",  6'b101011, 1'b1, F_RDY);
        cyc("rsw_decode", 6'b101011, rnd(), DEC);
        cyc("rsw_addr",   6'b101011, rnd(), MADDR);
        cyc("rsw_wr_wait", 6'b101011, 1'b0, MWR_WAIT);
        #2;
        mem_ready = 1'b1;
        rst = 1'b1;
        exp_cnt = '0;
        #1;
        exp_q.push_back({exp_err, exp_cnt, ZERO});
        check("async_reset_mid_wr");
        @(negedge clk);
        rst = 1'b0;

        // Four jumps retire: counter wraps back to zero
        for (int k = 0; k < 4; k++) begin
            cyc("wrap_fetch",  6'b000010, 1'b1, F_RDY);
            cyc("wrap_decode", 6'b000010, rnd(), DEC);
            cyc("wrap_jump",   6'b000010, rnd(), JMP);
        end
        cyc("wrap_refetch", 6'b000000, 1'b0, F_WAIT);
        checks++;
        assert (instr_count === 2'd0) else begin
            errors++;
            $error("FAIL wrap_count got=%0d exp=0", instr_count);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
